// File: rtl/arbiter_types.sv
// Shared types and constants for the cache arbiter.
//   arb_state_t   : arbiter FSM states
//   arb_owner_t   : which cache owns the current pmem transaction
//   LINE_OFFSET_W : byte-offset bits inside a 32-byte cacheline
package arbiter_types;

    localparam int unsigned LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        COOL
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Performance counters for the cache arbiter. Each counter advances by one on
// its strobe and wraps modulo 2^CNT_W.
//   clk_i            : system clock
//   rst_ni           : synchronous active-low reset, clears all counters
//   i_grant_inc_i    : I-side grant strobe
//   d_grant_inc_i    : D-side grant strobe
//   conflict_inc_i   : both-sides-requesting-in-IDLE strobe
//   i_grant_o        : I-side grants since reset
//   d_grant_o        : D-side grants since reset
//   conflict_o       : conflict cycles since reset
module arb_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_grant_inc_i,
    input  logic             d_grant_inc_i,
    input  logic             conflict_inc_i,
    output logic [CNT_W-1:0] i_grant_o,
    output logic [CNT_W-1:0] d_grant_o,
    output logic [CNT_W-1:0] conflict_o
);

    logic [CNT_W-1:0] i_grant_q, i_grant_d;
    logic [CNT_W-1:0] d_grant_q, d_grant_d;
    logic [CNT_W-1:0] conflict_q, conflict_d;

    always_comb begin
        i_grant_d  = i_grant_q;
        d_grant_d  = d_grant_q;
        conflict_d = conflict_q;
        if (i_grant_inc_i) begin
            i_grant_d = i_grant_q + CNT_W'(1);
        end
        if (d_grant_inc_i) begin
            d_grant_d = d_grant_q + CNT_W'(1);
        end
        if (conflict_inc_i) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            i_grant_q  <= '0;
            d_grant_q  <= '0;
            conflict_q <= '0;
        end else begin
            i_grant_q  <= i_grant_d;
            d_grant_q  <= d_grant_d;
            conflict_q <= conflict_d;
        end
    end

    assign i_grant_o  = i_grant_q;
    assign d_grant_o  = d_grant_q;
    assign conflict_o = conflict_q;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates cacheline misses and writebacks from the I-cache and D-cache onto
// one physical-memory port. The winning request is registered and held on the
// pmem side until pmem_resp; the owner then gets a one-cycle registered resp,
// followed by one dead cycle before the next arbitration.
//   clk, rst                         : clock, synchronous active-low reset
//   i_read/i_address                 : I-cache line read request (held until i_resp)
//   i_rdata/i_resp                   : I-cache returned line and completion pulse
//   d_read/d_write/d_address/d_wdata : D-cache line read / writeback request
//   d_rdata/d_resp                   : D-cache returned line and completion pulse
//   pmem_*                           : physical memory port
//   cnt_*                            : grant / conflict performance counters
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = 256,
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [CNT_W-1:0]  cnt_i_grant,
    output logic [CNT_W-1:0]  cnt_d_grant,
    output logic [CNT_W-1:0]  cnt_conflict
);

    localparam int unsigned LINE_ADDR_W = ADDR_W - LINE_OFFSET_W;

    arb_state_t        state_q;
    arb_owner_t        owner_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [ADDR_W-1:0] pmem_address_q;
    logic [LINE_W-1:0] pmem_wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              i_resp_q;
    logic              d_resp_q;

    // Arbitration decision, only acted on in IDLE.
    logic                   req_i;
    logic                   req_d;
    logic                   conflict;
    logic                   grant;
    logic                   grant_d;
    logic                   grant_write;
    arb_owner_t             grant_owner;
    logic [LINE_ADDR_W-1:0] grant_line;

    // Byte-offset bits are deliberately dropped from the line address.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{i_address[LINE_OFFSET_W-1:0], d_address[LINE_OFFSET_W-1:0]};

    assign req_i    = i_read;
    assign req_d    = d_read | d_write;
    assign conflict = req_i & req_d;
    assign grant    = (state_q == IDLE) & (req_i | req_d);

    always_comb begin
        grant_d = 1'b0;
        if (req_d && !req_i) begin
            grant_d = 1'b1;
        end else if (conflict) begin
            // Round robin hands the conflict to whoever did not own the last
            // transaction; owner resets to D so I wins the first conflict.
            grant_d = (ROUND_ROBIN != 0) ? (owner_q == OWN_I) : 1'b1;
        end
    end

    // A D request with both d_read and d_write is treated as a writeback.
    assign grant_write = grant_d & d_write;
    assign grant_owner = grant_d ? OWN_D : OWN_I;
    assign grant_line  = grant_d ? d_address[ADDR_W-1:LINE_OFFSET_W]
                                 : i_address[ADDR_W-1:LINE_OFFSET_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_D;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            i_resp_q       <= 1'b0;
            d_resp_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q        <= BUSY;
                        owner_q        <= grant_owner;
                        pmem_address_q <= {grant_line, {LINE_OFFSET_W{1'b0}}};
                        if (grant_d) begin
                            pmem_wdata_q <= d_wdata;
                        end
                        pmem_write_q   <= grant_write;
                        pmem_read_q    <= ~grant_write;
                    end
                end
                BUSY: begin
                    // pmem outputs are frozen here; only pmem_resp moves us on.
                    if (pmem_resp) begin
                        state_q      <= RESP;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        if (owner_q == OWN_I) begin
                            i_resp_q <= 1'b1;
                            if (pmem_read_q) begin
                                i_rdata_q <= pmem_rdata;
                            end
                        end else begin
                            d_resp_q <= 1'b1;
                            if (pmem_read_q) begin
                                d_rdata_q <= pmem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
                    state_q  <= COOL;
                end
                COOL: begin
                    // Dead cycle lets the served cache drop its request.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    arb_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk_i          (clk),
        .rst_ni         (rst),
        .i_grant_inc_i  (grant & ~grant_d),
        .d_grant_inc_i  (grant & grant_d),
        .conflict_inc_i ((state_q == IDLE) & conflict),
        .i_grant_o      (cnt_i_grant),
        .d_grant_o      (cnt_d_grant),
        .conflict_o     (cnt_conflict)
    );

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign i_resp       = i_resp_q;
    assign d_resp       = d_resp_q;

`ifndef SYNTHESIS
    a_owner_req_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q == BUSY) |-> ((owner_q == OWN_I) ? i_read : (d_read | d_write)));

    a_pmem_rw_excl: assert property (@(posedge clk) disable iff (!rst)
        !(pmem_read_q && pmem_write_q));

    a_resp_excl: assert property (@(posedge clk) disable iff (!rst)
        !(i_resp_q && d_resp_q));

    a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst)
        (state_q == IDLE) |-> !(d_read && d_write));
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A: ROUND_ROBIN = 1 ----------------
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] d_wdata, i_rdata, d_rdata;
    logic          i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic [CW-1:0] cnt_i_grant, cnt_d_grant, cnt_conflict;

    cache_arbiter #(
        .ADDR_W      (AW),
        .LINE_W      (LW),
        .ROUND_ROBIN (1),
        .CNT_W       (CW)
    ) u_dut_rr (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .cnt_i_grant  (cnt_i_grant),
        .cnt_d_grant  (cnt_d_grant),
        .cnt_conflict (cnt_conflict)
    );

    // Memory model A: raises pmem_resp mem_lat cycles after a request rises.
    logic          mem_en     = 1'b1;
    int            mem_lat    = 1;
    logic [LW-1:0] mem_line   = '0;
    int            mem_cnt    = 0;
    logic          model_resp = 1'b0;
    logic          force_resp = 1'b0;
    assign pmem_resp = model_resp | force_resp;

    always @(posedge clk) begin
        model_resp <= 1'b0;
        if (!rst || !mem_en) begin
            mem_cnt <= 0;
        end else if ((pmem_read || pmem_write) && !model_resp) begin
            if (mem_cnt >= mem_lat - 1) begin
                model_resp <= 1'b1;
                pmem_rdata <= mem_line;
                mem_cnt    <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    // ---------------- instance B: ROUND_ROBIN = 0 ----------------
    logic          b_i_read, b_d_read, b_d_write;
    logic [AW-1:0] b_i_address, b_d_address;
    logic [LW-1:0] b_d_wdata, b_i_rdata, b_d_rdata;
    logic          b_i_resp, b_d_resp, b_pmem_read, b_pmem_write, b_pmem_resp;
    logic [AW-1:0] b_pmem_address;
    logic [LW-1:0] b_pmem_wdata;
    logic [LW-1:0] b_pmem_rdata;
    logic [CW-1:0] b_cnt_i_grant, b_cnt_d_grant, b_cnt_conflict;

    cache_arbiter #(
        .ADDR_W      (AW),
        .LINE_W      (LW),
        .ROUND_ROBIN (0),
        .CNT_W       (CW)
    ) u_dut_fixed (
        .clk          (clk),
        .rst          (rst),
        .i_read       (b_i_read),
        .i_address    (b_i_address),
        .i_rdata      (b_i_rdata),
        .i_resp       (b_i_resp),
        .d_read       (b_d_read),
        .d_write      (b_d_write),
        .d_address    (b_d_address),
        .d_wdata      (b_d_wdata),
        .d_rdata      (b_d_rdata),
        .d_resp       (b_d_resp),
        .pmem_read    (b_pmem_read),
        .pmem_write   (b_pmem_write),
        .pmem_address (b_pmem_address),
        .pmem_wdata   (b_pmem_wdata),
        .pmem_rdata   (b_pmem_rdata),
        .pmem_resp    (b_pmem_resp),
        .cnt_i_grant  (b_cnt_i_grant),
        .cnt_d_grant  (b_cnt_d_grant),
        .cnt_conflict (b_cnt_conflict)
    );

    // Memory model B: fixed latency of 2.
    logic b_model_resp = 1'b0;
    int   b_cnt        = 0;
    assign b_pmem_resp  = b_model_resp;
    assign b_pmem_rdata = {8{32'h0B0B_0B0B}};

    always @(posedge clk) begin
        b_model_resp <= 1'b0;
        if (!rst) begin
            b_cnt <= 0;
        end else if ((b_pmem_read || b_pmem_write) && !b_model_resp) begin
            if (b_cnt >= 1) begin
                b_model_resp <= 1'b1;
                b_cnt        <= 0;
            end else begin
                b_cnt <= b_cnt + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // who: 1 = i_resp, 2 = d_resp, 0 = timed out
    task automatic wait_resp_a(output int who);
        who = 0;
        for (int n = 0; n < 100 && who == 0; n++) begin
            @(negedge clk);
            if (i_resp) who = 1;
            else if (d_resp) who = 2;
        end
    endtask

    task automatic wait_resp_b(output int who);
        who = 0;
        for (int n = 0; n < 100 && who == 0; n++) begin
            @(negedge clk);
            if (b_i_resp) who = 1;
            else if (b_d_resp) who = 2;
        end
    endtask

    typedef struct {
        logic          is_d;
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] line;
        int            lat;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vec[5];

    initial begin
        logic [LW-1:0] exp_i_rdata, exp_d_rdata;
        logic [LW-1:0] cap_wdata;
        logic [AW-1:0] cap_addr;
        int exp_ci, exp_cd;
        int cyc, rd_hi, wr_hi, resp_cyc, other_resp, extra_resp;
        logic busy_seen, hold_ok, own, other;
        int who;

        i_read = 0; d_read = 0; d_write = 0;
        i_address = '0; d_address = '0; d_wdata = '0;
        b_i_read = 0; b_d_read = 0; b_d_write = 0;
        b_i_address = '0; b_d_address = '0; b_d_wdata = '0;

        vec[0] = '{1'b0, 1'b0, 32'h0000_0064, '0, {8{32'hA1A1_0001}}, 10, 32'h0000_0060};
        vec[1] = '{1'b1, 1'b1, 32'h8000_01F0, {8{32'hB2B2_0002}}, '0, 3, 32'h8000_01E0};
        vec[2] = '{1'b1, 1'b0, 32'h1234_567F, {8{32'hC3C3_0003}}, {8{32'hD4D4_0004}}, 1,
                   32'h1234_5660};
        vec[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, '0, {8{32'hE5E5_0005}}, 2, 32'hFFFF_FFE0};
        vec[4] = '{1'b1, 1'b1, 32'h0000_001F, {8{32'hF6F6_0006}}, '0, 4, 32'h0000_0000};

        // ---------------- reset state ----------------
        apply_reset();
        chk32("rst_pmem_read", 32'(pmem_read), 0);
        chk32("rst_pmem_write", 32'(pmem_write), 0);
        chk32("rst_pmem_address", pmem_address, 0);
        chk32("rst_resp", 32'({i_resp, d_resp}), 0);
        chkw("rst_i_rdata", i_rdata, '0);
        chkw("rst_d_rdata", d_rdata, '0);
        chk32("rst_cnt_i", cnt_i_grant, 0);
        chk32("rst_cnt_d", cnt_d_grant, 0);
        chk32("rst_cnt_conflict", cnt_conflict, 0);

        // ---------------- single-requester vectors ----------------
        exp_i_rdata = '0; exp_d_rdata = '0; exp_ci = 0; exp_cd = 0;
        for (int k = 0; k < 5; k++) begin
            mem_lat  = vec[k].lat;
            mem_line = vec[k].line;
            if (vec[k].is_d) begin
                d_address = vec[k].addr;
                d_wdata   = vec[k].wdata;
                d_write   = vec[k].is_wr;
                d_read    = !vec[k].is_wr;
            end else begin
                i_address = vec[k].addr;
                i_read    = 1'b1;
            end
            // Request presented in cycle 1; resp expected in cycle lat+3.
            cyc = 1; rd_hi = 0; wr_hi = 0; resp_cyc = 0; other_resp = 0;
            busy_seen = 1'b0; hold_ok = 1'b1; cap_addr = '0; cap_wdata = '0;
            while (resp_cyc == 0 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (pmem_read) rd_hi++;
                if (pmem_write) wr_hi++;
                if (pmem_read || pmem_write) begin
                    if (!busy_seen) begin
                        busy_seen = 1'b1;
                        cap_addr  = pmem_address;
                        cap_wdata = pmem_wdata;
                    end else if (pmem_address !== cap_addr || pmem_wdata !== cap_wdata) begin
                        hold_ok = 1'b0;
                    end
                end
                own   = vec[k].is_d ? d_resp : i_resp;
                other = vec[k].is_d ? i_resp : d_resp;
                if (own) resp_cyc = cyc;
                if (other) other_resp++;
                // Scribble on the D-side inputs; pmem side must not follow.
                if (vec[k].is_d) begin
                    d_address = d_address ^ 32'h0000_0400;
                    d_wdata   = ~d_wdata;
                end
            end
            i_read = 0; d_read = 0; d_write = 0;
            if (vec[k].is_d) begin
                exp_cd++;
                if (!vec[k].is_wr) exp_d_rdata = vec[k].line;
            end else begin
                exp_ci++;
                exp_i_rdata = vec[k].line;
            end
            chk32($sformatf("v%0d_resp_cycle", k), resp_cyc, vec[k].lat + 3);
            chk32($sformatf("v%0d_pmem_address", k), cap_addr, vec[k].exp_addr);
            chk32($sformatf("v%0d_hold", k), 32'(hold_ok), 1);
            chk32($sformatf("v%0d_read_cycles", k), rd_hi, vec[k].is_wr ? 0 : vec[k].lat + 1);
            chk32($sformatf("v%0d_write_cycles", k), wr_hi, vec[k].is_wr ? vec[k].lat + 1 : 0);
            if (vec[k].is_d) chkw($sformatf("v%0d_pmem_wdata", k), cap_wdata, vec[k].wdata);
            chkw($sformatf("v%0d_i_rdata", k), i_rdata, exp_i_rdata);
            chkw($sformatf("v%0d_d_rdata", k), d_rdata, exp_d_rdata);
            extra_resp = 0;
            repeat (2) begin
                @(negedge clk);
                if (i_resp || d_resp) extra_resp++;
            end
            chk32($sformatf("v%0d_other_resp", k), other_resp, 0);
            chk32($sformatf("v%0d_single_pulse", k), extra_resp, 0);
            chk32($sformatf("v%0d_cnt_i", k), cnt_i_grant, exp_ci);
            chk32($sformatf("v%0d_cnt_d", k), cnt_d_grant, exp_cd);
            chk32($sformatf("v%0d_cnt_conflict", k), cnt_conflict, 0);
        end

        // ---------------- round-robin conflicts ----------------
        apply_reset();
        chk32("rr_reset_cnt_i", cnt_i_grant, 0);
        mem_lat = 2; mem_line = {8{32'h7777_1111}};
        i_address = 32'h0000_1000; d_address = 32'h0000_2000;
        i_read = 1; d_read = 1;
        @(negedge clk);
        chk32("rr_first_grant_addr", pmem_address, 32'h0000_1000);
        chk32("rr_first_read", 32'(pmem_read), 1);
        chk32("rr_conflict_1", cnt_conflict, 1);
        wait_resp_a(who);
        chk32("rr_first_owner", who, 1);
        chkw("rr_first_i_rdata", i_rdata, {8{32'h7777_1111}});
        i_read = 0;
        @(negedge clk);                       // COOL: I comes straight back
        i_read = 1; i_address = 32'h0000_3000;
        @(negedge clk);                       // IDLE
        chk32("rr_idle_gap", 32'(pmem_read), 0);
        @(negedge clk);
        chk32("rr_d_grant_addr", pmem_address, 32'h0000_2000);
        chk32("rr_d_grant_read", 32'(pmem_read), 1);
        chk32("rr_conflict_2", cnt_conflict, 2);
        wait_resp_a(who);
        chk32("rr_second_owner", who, 2);
        d_read = 0;
        wait_resp_a(who);
        chk32("rr_third_owner", who, 1);
        chk32("rr_third_addr_latched", pmem_address, 32'h0000_3000);
        i_read = 0;
        repeat (2) @(negedge clk);
        chk32("rr_cnt_i", cnt_i_grant, 2);
        chk32("rr_cnt_d", cnt_d_grant, 1);
        chk32("rr_cnt_conflict", cnt_conflict, 2);

        // ---------------- fixed priority, D always wins ----------------
        b_i_address = 32'h0000_4000; b_d_address = 32'h0000_5000;
        b_i_read = 1; b_d_read = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk32($sformatf("fixed_grant%0d_addr", k), b_pmem_address, 32'h0000_5000);
            wait_resp_b(who);
            chk32($sformatf("fixed_grant%0d_owner", k), who, 2);
            b_d_read = 0;
            @(negedge clk);                   // COOL
            if (k < 2) b_d_read = 1;
            @(negedge clk);                   // IDLE
        end
        @(negedge clk);
        chk32("fixed_i_grant_addr", b_pmem_address, 32'h0000_4000);
        wait_resp_b(who);
        chk32("fixed_i_owner", who, 1);
        b_i_read = 0;
        repeat (2) @(negedge clk);
        chk32("fixed_cnt_d", b_cnt_d_grant, 3);
        chk32("fixed_cnt_i", b_cnt_i_grant, 1);
        chk32("fixed_cnt_conflict", b_cnt_conflict, 3);

        // ---------------- reset in the middle of BUSY ----------------
        mem_en = 1'b0;
        i_address = 32'h0000_0064; i_read = 1;   // cycle 1
        repeat (3) @(negedge clk);               // cycle 4
        chk32("midrst_busy_read", 32'(pmem_read), 1);
        @(negedge clk);                          // cycle 5
        rst = 1'b0;
        @(negedge clk);
        chk32("midrst_read_dropped", 32'(pmem_read), 0);
        force_resp = 1'b1;
        @(negedge clk);
        rst = 1'b1; i_read = 0;
        @(negedge clk);
        force_resp = 1'b0;
        extra_resp = 0;
        repeat (4) begin
            @(negedge clk);
            if (i_resp || d_resp) extra_resp++;
        end
        chk32("midrst_no_resp", extra_resp, 0);
        chkw("midrst_i_rdata", i_rdata, '0);
        chk32("midrst_cnt_i", cnt_i_grant, 0);
        chk32("midrst_cnt_d", cnt_d_grant, 0);
        chk32("midrst_cnt_conflict", cnt_conflict, 0);
        chk32("midrst_pmem_read", 32'(pmem_read), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Arbitrates cacheline-granular misses and writebacks from the I-cache and D-cache onto the single physical-memory port that feeds the cacheline adaptor and the parameterized memory model.
- Registers the winning request, holds the pmem side stable until `pmem_resp`, and returns a one-cycle registered response to the owner.
- Exposes grant and conflict counters consumed by the bench performance reporting.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cacheline width in bits
- ROUND_ROBIN, 1, 1 = alternate on conflict; 0 = D-side always wins
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  ADDR_W  I-cache line address, bits [4:0] ignored
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache writeback request
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  physical read request
- pmem_write  out  1  physical write request
- pmem_address  out  ADDR_W  line-aligned address, low 5 bits forced to 0
- pmem_wdata  out  LINE_W  writeback data
- pmem_rdata  in  LINE_W  read data, valid with pmem_resp
- pmem_resp  in  1  physical completion pulse
- cnt_i_grant  out  CNT_W  I-side grants since reset
- cnt_d_grant  out  CNT_W  D-side grants since reset
- cnt_conflict  out  CNT_W  IDLE cycles with both sides requesting

Behaviour:
- States: IDLE, BUSY, RESP, COOL; a registered owner bit records I or D.
- Reset (rst==0 at a rising edge):
  - State goes to IDLE and owner to D, so the first conflict favours I when ROUND_ROBIN=1.
  - All outputs go to 0, including rdata and counters.
  - Any in-flight pmem_resp is ignored.
  - Mid-operation reset drops pmem_read/pmem_write at that same edge.
- IDLE:
  - req_i = i_read; req_d = d_read | d_write.
  - Neither requesting: stay in IDLE.
  - One side requesting: grant it.
  - Both requesting, ROUND_ROBIN=1: grant the side that is not the previous owner. ROUND_ROBIN=0: grant D. Either way, cnt_conflict increments.
  - On grant (edge N):
    - Register pmem_address = {addr[ADDR_W-1:5], 5'b0} and pmem_wdata = d_wdata (D only).
    - Assert pmem_write if the D side has d_write; otherwise assert pmem_read.
    - Set owner, increment the matching grant counter, go to BUSY.
  - d_read and d_write together: treated as a write. This is a protocol violation, flagged by an assertion.
- BUSY:
  - pmem outputs are held constant, independent of requester inputs.
  - When pmem_resp==1 at an edge:
    - Deassert pmem_read/pmem_write.
    - Capture pmem_rdata into the owner's rdata register (writes leave rdata unchanged).
    - Go to RESP.
- RESP: owner's resp==1 for exactly this one cycle; go to COOL.
- COOL:
  - One dead cycle, no grant, so the served cache deasserts its request.
  - Then go to IDLE.
  - A request pending from the other side is granted in that IDLE cycle.
- Latency: from request seen in IDLE to resp is 3 + L cycles, where L = cycles from pmem_read rising to pmem_resp.
- Back-to-back requests from a single requester have a minimum spacing of 4 cycles (IDLE→BUSY→RESP→COOL) plus L.
- i_rdata/d_rdata hold their last value between transactions.
- Counters wrap modulo 2^CNT_W with no saturation.
- pmem_resp outside BUSY is ignored.
- Assertions:
  - Owner's request stays high through BUSY.
  - pmem_read and pmem_write are never both high.
  - i_resp and d_resp are never both high.

Decomposition:
- Package arbiter_types:
  - typedef arb_state_t {IDLE, BUSY, RESP, COOL}
  - typedef arb_owner_t {OWN_I, OWN_D}
  - localparam LINE_OFFSET_W = 5
- One sub-module, arb_perf_counters: the three CNT_W counters with increment strobes from the FSM.
- FSM, datapath registers and muxing stay in cache_arbiter.

Test Plan:
- I-only read: i_read=1, i_address=0x0000_0064, memory returns line A after L=10 → pmem_read high for 11 cycles with pmem_address=0x0000_0060; i_resp pulses once at cycle 13 with i_rdata=A; cnt_i_grant=1.
- D writeback: d_write=1, d_address=0x8000_01F0, d_wdata=pattern B → pmem_write=1, pmem_address=0x8000_01E0, pmem_wdata=B; d_resp pulses once; d_rdata unchanged.
- Simultaneous requests, ROUND_ROBIN=1, after reset:
  - Same cycle: i_read and d_read both high → I is granted first and cnt_conflict=1.
  - After I's COOL, D is granted with no extra idle cycle.
  - Repeating the conflict then grants D first.
- Simultaneous requests, ROUND_ROBIN=0: three back-to-back conflicts → D is granted every time, and the I request waits until D drops.
- Reset mid-BUSY: drive rst=0 at cycle 5 of a read → pmem_read=0 the next cycle; a late pmem_resp produces no i_resp; all counters are 0.
- Held-stable check: during BUSY, toggle d_address/d_wdata every cycle → pmem_address/pmem_wdata stay constant until pmem_resp.
